// File: rtl/mem_stage_pkg.sv
// Shared bus types, funct3 access codes and FSM encodings for the MEM stage.
package mem_stage_pkg;

  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [5:0]  stall_ctl_t;

  localparam reg_addr_t NopRegAddr = 5'd0;
  localparam int        StallMem   = 4;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // The low two funct3 bits encode the access size for loads and stores alike.
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [1:0] MemIdle = 2'd0;
  localparam logic [1:0] MemWait = 2'd1;
  localparam logic [1:0] MemDone = 2'd2;

  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SizeByte: return 1'b1;
      SizeHalf: return !off[0];
      default:  return off == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus request/response bundle between the MEM stage and the data memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic     req;
  logic     we;
  reg_bus_t addr;
  reg_bus_t wdata;
  logic [3:0] wstrb;
  reg_bus_t rdata;
  logic     ack;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack);

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the byte/half lane addressed by the low address bits and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  reg_bus_t   rdata,
  input  logic [1:0] off,
  input  logic [2:0] funct3,
  output reg_bus_t   ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  // funct3[2] set means the unsigned variants LBU/LHU.
  always_comb begin
    case (off)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    sext   = !funct3[2];
    case (funct3[1:0])
      SizeByte: ldata = {{24{sext & lane_b[7]}}, lane_b};
      SizeHalf: ldata = {{16{sext & lane_h[15]}}, lane_h};
      default:  ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through plus load/store over a req/ack data bus
// with lane steering, stall requests and a timeout abort.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_addr_t   rd_i,
  input  logic        regwe_i,
  input  reg_bus_t    alu_i,
  input  logic        memre_i,
  input  logic        memwe_i,
  input  logic [2:0]  funct3_i,
  input  reg_bus_t    sdata_i,
  input  stall_ctl_t  stall_i,
  output reg_addr_t   rd_o,
  output logic        regwe_o,
  output reg_bus_t    wbdata_o,
  output logic        stallreq_o,
  mem_stage_if.master dbus,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt;
  reg_bus_t   rdata_q;
  reg_bus_t   ldata;
  reg_bus_t   st_wdata;
  logic [3:0] st_wstrb;
  logic       is_mem, aligned, mem_op, mem_stall;
  logic       busy_req, ack, abort;
  logic       unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  assign is_mem    = memre_i | memwe_i;
  assign aligned   = access_aligned(funct3_i[1:0], alu_i[1:0]);
  assign mem_op    = is_mem & aligned;
  assign mem_stall = stall_i[StallMem];
  assign busy_req  = ((state == MemIdle) && mem_op) || (state == MemWait);
  assign ack       = busy_req & dbus.ack;
  assign abort     = (state == MemWait) && !dbus.ack && (cnt == CntLast);

  load_align u_load_align (
    .rdata  (dbus.rdata),
    .off    (alu_i[1:0]),
    .funct3 (funct3_i),
    .ldata  (ldata)
  );

  always_comb begin
    st_wdata = sdata_i;
    st_wstrb = 4'b1111;
    case (funct3_i[1:0])
      SizeByte: begin
        st_wdata = {4{sdata_i[7:0]}};
        st_wstrb = 4'b0001 << alu_i[1:0];
      end
      SizeHalf: begin
        st_wdata = {2{sdata_i[15:0]}};
        st_wstrb = alu_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // A completed access only parks in DONE when MEM is frozen and cannot consume it.
  always_comb begin
    state_nxt = state;
    case (state)
      MemIdle: begin
        if (mem_op) state_nxt = ack ? (mem_stall ? MemDone : MemIdle) : MemWait;
      end
      MemWait: begin
        if (ack || abort) state_nxt = mem_stall ? MemDone : MemIdle;
      end
      MemDone: begin
        if (!mem_stall) state_nxt = MemIdle;
      end
      default: state_nxt = MemIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MemIdle;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state != MemWait) cnt <= '0;
      else if (!ack)        cnt <= cnt + 8'd1;
      if (ack && mem_stall) rdata_q <= ldata;
      else if (abort)       rdata_q <= '0;
    end
  end

  // Every output is gated by reset so an in-flight request vanishes immediately.
  always_comb begin
    rd_o       = NopRegAddr;
    regwe_o    = 1'b0;
    wbdata_o   = '0;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    dbus.req   = 1'b0;
    dbus.we    = 1'b0;
    dbus.addr  = '0;
    dbus.wdata = '0;
    dbus.wstrb = '0;
    if (!rst) begin
      rd_o       = rd_i;
      misalign_o = is_mem & !aligned;
      regwe_o    = regwe_i & !memwe_i & !misalign_o & !abort;
      bus_err_o  = abort;
      if (busy_req) begin
        dbus.req   = 1'b1;
        dbus.we    = memwe_i;
        dbus.addr  = {alu_i[31:2], 2'b00};
        dbus.wdata = memwe_i ? st_wdata : '0;
        dbus.wstrb = memwe_i ? st_wstrb : 4'b0000;
        stallreq_o = !dbus.ack & !abort;
      end
      if (state == MemDone)          wbdata_o = rdata_q;
      else if (mem_op && !memwe_i)   wbdata_o = ldata;
      else                           wbdata_o = alu_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model, plus
// directed cases with hand-computed expectations.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk, rst;
  logic [4:0]  rd_i;
  logic        regwe_i;
  logic [31:0] alu_i;
  logic        memre_i, memwe_i;
  logic [2:0]  funct3_i;
  logic [31:0] sdata_i;
  logic [5:0]  stall_i;
  logic [4:0]  rd_o;
  logic        regwe_o;
  logic [31:0] wbdata_o;
  logic        stallreq_o, misalign_o, bus_err_o;

  mem_stage_if dbus();

  int errors = 0;
  int checks = 0;

  // Model context: request cycles already spent on the current access, and a parked result.
  int          m_age  = 0;
  bit          m_held = 1'b0;
  logic [31:0] m_word = '0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_i       (rd_i),
    .regwe_i    (regwe_i),
    .alu_i      (alu_i),
    .memre_i    (memre_i),
    .memwe_i    (memwe_i),
    .funct3_i   (funct3_i),
    .sdata_i    (sdata_i),
    .stall_i    (stall_i),
    .rd_o       (rd_o),
    .regwe_o    (regwe_o),
    .wbdata_o   (wbdata_o),
    .stallreq_o (stallreq_o),
    .dbus       (dbus),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rd, input logic rw,
                               input logic [31:0] alu, input logic re, input logic wr,
                               input logic [2:0] f3, input logic [31:0] sd,
                               input logic [5:0] st, input logic ack, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    rst        = r;
    rd_i       = rd;
    regwe_i    = rw;
    alu_i      = alu;
    memre_i    = re;
    memwe_i    = wr;
    funct3_i   = f3;
    sdata_i    = sd;
    stall_i    = st;
    dbus.ack   = ack;
    dbus.rdata = rdata;
    @(negedge clk);
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int          nb;
    logic [31:0] raw;
    nb  = access_bytes(f3);
    raw = word >> (8 * (addr % 4));
    if (nb == 4) return word;
    if (nb == 1) begin
      raw = raw & 32'h0000_00FF;
      if (!f3[2] && raw >= 32'h80) raw = raw | 32'hFFFF_FF00;
    end else begin
      raw = raw & 32'h0000_FFFF;
      if (!f3[2] && raw >= 32'h8000) raw = raw | 32'hFFFF_0000;
    end
    return raw;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] sd);
    case (access_bytes(f3))
      1:       return (sd & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    int off;
    nb  = access_bytes(f3);
    off = int'(addr % 4);
    if (nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  // Single compare process: derive every output from the current inputs and model context.
  always @(negedge clk) begin : compare
    int          nb;
    bit          mem, mis, ack, abort, e_req, e_regwe, e_stallreq;
    logic [31:0] lv;
    nb  = access_bytes(funct3_i);
    mem = memre_i | memwe_i;
    mis = mem && ((alu_i % 32'(nb)) != 0);
    ack = dbus.ack;
    lv  = load_value(funct3_i, alu_i, dbus.rdata);
    if (rst) begin
      checkOutput("rst rd_o", 32'(rd_o), 32'd0);
      checkOutput("rst regwe_o", 32'(regwe_o), 32'd0);
      checkOutput("rst wbdata_o", wbdata_o, 32'd0);
      checkOutput("rst stallreq_o", 32'(stallreq_o), 32'd0);
      checkOutput("rst dbus_req", 32'(dbus.req), 32'd0);
      checkOutput("rst dbus_we", 32'(dbus.we), 32'd0);
      checkOutput("rst dbus_addr", dbus.addr, 32'd0);
      checkOutput("rst dbus_wdata", dbus.wdata, 32'd0);
      checkOutput("rst dbus_wstrb", 32'(dbus.wstrb), 32'd0);
      checkOutput("rst misalign_o", 32'(misalign_o), 32'd0);
      checkOutput("rst bus_err_o", 32'(bus_err_o), 32'd0);
      m_age  = 0;
      m_held = 1'b0;
      m_word = '0;
    end else begin
      e_req      = !m_held && mem && !mis;
      abort      = e_req && !ack && (m_age == TO);
      e_regwe    = regwe_i && !memwe_i && !mis && !abort;
      e_stallreq = e_req && !ack && !abort;
      checkOutput("rd_o", 32'(rd_o), 32'(rd_i));
      checkOutput("regwe_o", 32'(regwe_o), 32'(e_regwe));
      checkOutput("stallreq_o", 32'(stallreq_o), 32'(e_stallreq));
      checkOutput("misalign_o", 32'(misalign_o), 32'(mis));
      checkOutput("bus_err_o", 32'(bus_err_o), 32'(abort));
      checkOutput("dbus_req", 32'(dbus.req), 32'(e_req));
      if (e_req) begin
        checkOutput("dbus_addr", dbus.addr, alu_i & 32'hFFFF_FFFC);
        checkOutput("dbus_we", 32'(dbus.we), 32'(memwe_i));
        if (memwe_i) begin
          checkOutput("dbus_wdata", dbus.wdata, store_data(funct3_i, sdata_i));
          checkOutput("dbus_wstrb", 32'(dbus.wstrb), 32'(store_strb(funct3_i, alu_i)));
        end
      end
      if (m_held) begin
        if (!memwe_i) checkOutput("wbdata_o held", wbdata_o, m_word);
      end else if (!mem) begin
        checkOutput("wbdata_o pass", wbdata_o, alu_i);
      end else if (e_req && !memwe_i && ack && e_regwe) begin
        checkOutput("wbdata_o load", wbdata_o, lv);
      end
      if (m_held) begin
        if (!stall_i[4]) m_held = 1'b0;
      end else if (e_req) begin
        if (ack || abort) begin
          m_age = 0;
          if (stall_i[4]) begin
            m_held = 1'b1;
            m_word = ack ? lv : 32'd0;
          end
        end else begin
          m_age++;
        end
      end
    end
  end

  logic [2:0]  lf3 [5];
  logic [4:0]  r_rd;
  logic        r_rw, r_re, r_wr, r_rst, r_hit;
  logic [31:0] r_alu, r_sd;
  logic [2:0]  r_f3;
  logic [5:0]  r_st;
  int          kind, delay, last;

  initial begin
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1; rd_i = 5'd9; regwe_i = 1'b1; alu_i = 32'h55; memre_i = 1'b1; memwe_i = 1'b0;
    funct3_i = 3'b010; sdata_i = '0; stall_i = '0; dbus.ack = 1'b1; dbus.rdata = 32'hFFFF_FFFF;

    // Reset with a live load on the inputs: everything must read zero.
    applyStimulus(1, 5'd9, 1, 32'h55, 1, 0, 3'b010, 0, 6'd0, 1, 32'hFFFF_FFFF);
    checkOutput("reset rd_o", 32'(rd_o), 32'd0);
    checkOutput("reset wbdata_o", wbdata_o, 32'd0);
    checkOutput("reset dbus_req", 32'(dbus.req), 32'd0);
    checkOutput("reset stallreq_o", 32'(stallreq_o), 32'd0);

    applyStimulus(0, 5'd5, 1, 32'h1234, 0, 0, 3'b000, 0, 6'd0, 0, 0);
    checkOutput("alu rd_o", 32'(rd_o), 32'd5);
    checkOutput("alu wbdata_o", wbdata_o, 32'h1234);
    checkOutput("alu dbus_req", 32'(dbus.req), 32'd0);
    checkOutput("alu stallreq_o", 32'(stallreq_o), 32'd0);

    applyStimulus(0, 5'd7, 1, 32'h103, 1, 0, 3'b000, 0, 6'd0, 1, 32'h80FF_0000);
    checkOutput("lb wbdata_o", wbdata_o, 32'hFFFF_FF80);
    checkOutput("lb dbus_addr", dbus.addr, 32'h100);
    checkOutput("lb stallreq_o", 32'(stallreq_o), 32'd0);
    applyStimulus(0, 5'd7, 1, 32'h103, 1, 0, 3'b100, 0, 6'd0, 1, 32'h80FF_0000);
    checkOutput("lbu wbdata_o", wbdata_o, 32'h0000_0080);

    applyStimulus(0, 5'd3, 1, 32'h202, 0, 1, 3'b001, 32'hABCD, 6'd0, 1, 0);
    checkOutput("sh dbus_addr", dbus.addr, 32'h200);
    checkOutput("sh dbus_wdata", dbus.wdata, 32'hABCD_ABCD);
    checkOutput("sh dbus_wstrb", 32'(dbus.wstrb), 32'hC);
    checkOutput("sh regwe_o", 32'(regwe_o), 32'd0);

    for (int k = 0; k <= 3; k++) begin
      applyStimulus(0, 5'd1, 1, 32'h300, 1, 0, 3'b010, 0, 6'd0, k == 3, 32'hDEAD_BEEF);
      checkOutput("lw3 stallreq_o", 32'(stallreq_o), (k < 3) ? 32'd1 : 32'd0);
    end
    checkOutput("lw3 wbdata_o", wbdata_o, 32'hDEAD_BEEF);

    // No ack at all: the fifth request cycle aborts, and with MEM frozen the result parks as zero.
    for (int k = 0; k <= 4; k++) begin
      applyStimulus(0, 5'd2, 1, 32'h304, 1, 0, 3'b010, 0, 6'b010000, 0, 32'h1111_1111);
      checkOutput("timeout bus_err_o", 32'(bus_err_o), (k == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("timeout regwe_o", 32'(regwe_o), 32'd0);
    checkOutput("timeout stallreq_o", 32'(stallreq_o), 32'd0);
    applyStimulus(0, 5'd2, 1, 32'h304, 1, 0, 3'b010, 0, 6'b010000, 0, 32'h1111_1111);
    checkOutput("timeout dropped req", 32'(dbus.req), 32'd0);
    checkOutput("timeout wbdata_o", wbdata_o, 32'd0);
    applyStimulus(0, 5'd2, 1, 32'h304, 1, 0, 3'b010, 0, 6'd0, 0, 32'h1111_1111);

    applyStimulus(0, 5'd4, 1, 32'h308, 1, 0, 3'b010, 0, 6'd0, 0, 0);
    applyStimulus(0, 5'd4, 1, 32'h308, 1, 0, 3'b010, 0, 6'd0, 0, 0);
    applyStimulus(1, 5'd4, 1, 32'h308, 1, 0, 3'b010, 0, 6'd0, 1, 32'h2222_2222);
    checkOutput("rst mid-wait req", 32'(dbus.req), 32'd0);
    applyStimulus(0, 5'd4, 1, 32'hCAFE, 0, 0, 3'b000, 0, 6'd0, 1, 32'h2222_2222);
    checkOutput("after rst req", 32'(dbus.req), 32'd0);
    checkOutput("after rst wbdata_o", wbdata_o, 32'hCAFE);

    applyStimulus(0, 5'd6, 1, 32'h102, 1, 0, 3'b010, 0, 6'd0, 1, 0);
    checkOutput("misalign misalign_o", 32'(misalign_o), 32'd1);
    checkOutput("misalign dbus_req", 32'(dbus.req), 32'd0);
    checkOutput("misalign regwe_o", 32'(regwe_o), 32'd0);

    applyStimulus(0, 5'd8, 1, 32'h400, 1, 0, 3'b010, 0, 6'b010000, 1, 32'h1122_3344);
    checkOutput("stalled ack wbdata_o", wbdata_o, 32'h1122_3344);
    applyStimulus(0, 5'd8, 1, 32'h400, 1, 0, 3'b010, 0, 6'b010000, 1, 32'h5555_5555);
    checkOutput("done wbdata_o", wbdata_o, 32'h1122_3344);
    checkOutput("done dbus_req", 32'(dbus.req), 32'd0);
    checkOutput("done stallreq_o", 32'(stallreq_o), 32'd0);
    applyStimulus(0, 5'd8, 1, 32'h400, 1, 0, 3'b010, 0, 6'd0, 0, 32'h6666_6666);
    checkOutput("release wbdata_o", wbdata_o, 32'h1122_3344);
    applyStimulus(0, 5'd8, 1, 32'h77, 0, 0, 3'b000, 0, 6'd0, 0, 0);
    checkOutput("back to idle wbdata_o", wbdata_o, 32'h77);

    for (int n = 0; n < 400; n++) begin
      kind  = $urandom_range(0, 9);
      r_rd  = 5'($urandom);
      r_rw  = ($urandom_range(0, 3) != 0);
      r_alu = $urandom;
      r_sd  = $urandom;
      r_re  = 1'b0;
      r_wr  = 1'b0;
      r_f3  = 3'($urandom_range(0, 7));
      if (kind >= 3 && kind < 9) begin
        if (kind < 6) begin
          r_re = 1'b1;
          r_f3 = lf3[$urandom_range(0, 4)];
        end else begin
          r_wr = 1'b1;
          r_f3 = 3'($urandom_range(0, 2));
        end
        if (r_f3[1:0] == 2'b01)      r_alu[0]   = 1'b0;
        else if (r_f3[1:0] == 2'b10) r_alu[1:0] = 2'b00;
      end else if (kind == 9) begin
        r_re = $urandom_range(0, 1) != 0;
        r_wr = !r_re;
        r_f3 = $urandom_range(0, 1) != 0 ? 3'b001 : 3'b010;
        if (r_f3 == 3'b001) r_alu[0]   = 1'b1;
        else                r_alu[1:0] = 2'($urandom_range(1, 3));
      end

      if ((r_re || r_wr) && kind != 9) begin
        delay = $urandom_range(0, TO + 1);
        last  = (delay < TO) ? delay : TO;
        r_hit = 1'b0;
        r_st  = '0;
        for (int k = 0; k <= last; k++) begin
          r_rst = (k > 0) && ($urandom_range(0, 40) == 0);
          r_st  = 6'($urandom);
          applyStimulus(r_rst, r_rd, r_rw, r_alu, r_re, r_wr, r_f3, r_sd, r_st,
                        k == delay, $urandom);
          if (r_rst) begin
            r_hit = 1'b1;
            break;
          end
        end
        if (!r_hit) begin
          for (int h = 0; h < 6 && r_st[4]; h++) begin
            r_st = 6'($urandom);
            if (h == 5) r_st[4] = 1'b0;
            applyStimulus(0, r_rd, r_rw, r_alu, r_re, r_wr, r_f3, r_sd, r_st,
                          $urandom_range(0, 1) != 0, $urandom);
          end
        end
      end else begin
        applyStimulus(0, r_rd, r_rw, r_alu, r_re, r_wr, r_f3, r_sd, 6'($urandom),
                      $urandom_range(0, 1) != 0, $urandom);
      end
    end

    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
